// File: rtl/keypad_col_scanner_if.sv
// Keypad scanner bundle: column-drive / row-sense pins plus decoded key outputs.
// master = the scanner, slave = the keypad/consumer side.
interface keypad_col_scanner_if;
    logic [3:0] row;        // active-low rows, asynchronous to clk
    logic [3:0] col;        // one-hot active-low column drive
    logic [3:0] key_code;   // last accepted key
    logic       key_valid;  // one-cycle pulse on a new accepted key
    logic       key_held;   // accepted key still pressed

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_col_scanner.sv
// 4x4 keypad column scanner: drives one column low at a time, samples the
// synchronized rows after a settle time, resolves each full sweep to
// NONE / KEY / MULTI and debounces over consecutive sweeps.
module keypad_col_scanner #(
    parameter int SETTLE_CYCLES   = 100000,  // >= 4
    parameter int DEBOUNCE_SWEEPS = 4        // 1..15
) (
    input logic                  clk,
    input logic                  rst,
    keypad_col_scanner_if.master kp
);
    localparam int            CW          = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    DEB_N       = 4'(DEBOUNCE_SWEEPS);

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} resKind_t;

    logic [3:0]      rowMeta, rowSync;
    logic [CW-1:0]   settleCnt;
    logic [1:0]      colIdx, nextColIdx;
    logic [3:0]      colReg;
    logic [3:0][3:0] rowSamp;      // rowSamp[c] = rows seen while column c was driven
    logic            evalPending;  // high the cycle after the column-3 sample

    resKind_t        curKind, prevKind;
    logic [3:0]      curCode, prevCode;
    logic [4:0]      lowCnt;
    logic [3:0]      stableCnt, nextStable;
    logic            sameAsPrev, wantHeld, differs;

    logic [3:0]      codeReg;
    logic            validReg, heldReg;

    assign kp.col       = colReg;
    assign kp.key_code  = codeReg;
    assign kp.key_valid = validReg;
    assign kp.key_held  = heldReg;

    assign nextColIdx = colIdx + 2'd1;

    // Key legend: rows r0..r3 against columns c0..c3.
    function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Two-flop synchronizer; idle rows read as all-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowMeta <= 4'b1111;
            rowSync <= 4'b1111;
        end else begin
            rowMeta <= kp.row;
            rowSync <= rowMeta;
        end
    end

    // Column rotation: hold each column for SETTLE_CYCLES, sample rows on the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settleCnt   <= '0;
            colIdx      <= 2'd0;
            colReg      <= 4'b0111;
            rowSamp     <= '1;
            evalPending <= 1'b0;
        end else if (settleCnt == SETTLE_LAST) begin
            settleCnt        <= '0;
            rowSamp[colIdx]  <= rowSync;
            colIdx           <= nextColIdx;
            colReg           <= ~(4'b1000 >> nextColIdx);
            evalPending      <= (colIdx == 2'd3);
        end else begin
            settleCnt   <= settleCnt + CW'(1);
            evalPending <= 1'b0;
        end
    end

    // Resolve the 16 sampled switch states of the finished sweep.
    always_comb begin
        lowCnt  = '0;
        curCode = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!rowSamp[c][r]) begin
                    lowCnt  = lowCnt + 5'd1;
                    curCode = keyMap(2'(r), 2'(c));
                end
            end
        end
        if (lowCnt == 5'd0)      curKind = RES_NONE;
        else if (lowCnt == 5'd1) curKind = RES_KEY;
        else                     curKind = RES_MULTI;
    end

    // Stability run length and whether the sweep would change the accepted state.
    always_comb begin
        sameAsPrev = (curKind == prevKind) && ((curKind != RES_KEY) || (curCode == prevCode));
        if (!sameAsPrev)              nextStable = 4'd1;
        else if (stableCnt == DEB_N)  nextStable = DEB_N;
        else                          nextStable = stableCnt + 4'd1;
        // MULTI is accepted as "no key" so ghosting never produces a code.
        wantHeld = (curKind == RES_KEY);
        differs  = wantHeld ? (!heldReg || (curCode != codeReg)) : heldReg;
    end

    // Debounce and accepted-key outputs, updated once per sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevKind  <= RES_NONE;
            prevCode  <= 4'h0;
            stableCnt <= 4'd0;
            codeReg   <= 4'h0;
            heldReg   <= 1'b0;
            validReg  <= 1'b0;
        end else begin
            validReg <= 1'b0;
            if (evalPending) begin
                prevKind  <= curKind;
                prevCode  <= curCode;
                stableCnt <= nextStable;
                if ((nextStable == DEB_N) && differs) begin
                    heldReg <= wantHeld;
                    if (wantHeld) begin
                        codeReg  <= curCode;
                        validReg <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_col_scanner.sv
// Bench for keypad_col_scanner: a switch-matrix keypad model drives the rows,
// and a sweep-level reference model predicts the accepted key state.
module tb_keypad_col_scanner;
    localparam int S = 4;  // settle cycles per column
    localparam int N = 3;  // debounce sweeps

    logic        clk;
    logic        rst;
    logic [15:0] pressed;  // bit r*4+c = key at row r, column c is down
    int          tests;
    int          fails;

    logic [3:0]  keyMap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'h0, 4'hF, 4'hE, 4'hD};

    // reference state: history of sweep results (-1 none, -2 multi, else code)
    int          hist[$];
    logic        mHeld;
    logic [3:0]  mCode;
    logic        mPulse;

    keypad_col_scanner_if kp();

    keypad_col_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_SWEEPS(N)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    // Passive switch matrix: a row reads low if any pressed key on it sits in a driven column.
    function automatic logic [3:0] rowsFor(input logic [3:0] colv, input logic [15:0] p);
        logic [3:0] r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (p[rr*4+cc] && !colv[3-cc]) r[rr] = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] colFor(input int idx);
        logic [3:0] one = 4'b1000;
        return ~(one >> idx);
    endfunction

    assign kp.row = rowsFor(kp.col, pressed);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sweep-level model: accept when the last N results agree and differ from the accepted state.
    task automatic modelSweep(input logic [15:0] p);
        int  res;
        int  n;
        bit  allSame;
        n   = $countones(p);
        res = -1;
        if (n > 1) res = -2;
        else if (n == 1) for (int i = 0; i < 16; i++) if (p[i]) res = int'(keyMap[i]);
        hist.push_back(res);
        if (hist.size() > N) void'(hist.pop_front());
        mPulse = 1'b0;
        if (hist.size() == N) begin
            allSame = 1'b1;
            foreach (hist[i]) if (hist[i] != res) allSame = 1'b0;
            if (allSame) begin
                if (res >= 0) begin
                    if (!mHeld || mCode != res[3:0]) begin
                        mHeld  = 1'b1;
                        mCode  = res[3:0];
                        mPulse = 1'b1;
                    end
                end else begin
                    mHeld = 1'b0;
                end
            end
        end
    endtask

    // One full sweep with the given keys held, checking every cycle.
    task automatic sweep(input logic [15:0] p);
        pressed = p;
        for (int i = 0; i < 4*S; i++) begin
            @(posedge clk); #1;
            check("key_valid", kp.key_valid, (i == 0) ? mPulse : 1'b0);
            check("key_held",  kp.key_held,  mHeld);
            check("key_code",  kp.key_code,  mCode);
            check("col",       kp.col,       colFor(((i + 1) % (4*S)) / S));
        end
        modelSweep(p);
    endtask

    task automatic sweeps(input logic [15:0] p, input int cnt);
        for (int k = 0; k < cnt; k++) sweep(p);
    endtask

    // Run into column 2, then reset asynchronously between clock edges.
    task automatic midSweepReset();
        for (int k = 0; k < 4*S && kp.col != 4'b1101; k++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_col", kp.col, 4'b1101);
        #2 rst = 1'b1;
        #1;
        check("rst_col",   kp.col,       4'b0111);
        check("rst_code",  kp.key_code,  4'h0);
        check("rst_valid", kp.key_valid, 1'b0);
        check("rst_held",  kp.key_held,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        mHeld  = 1'b0;
        mCode  = 4'h0;
        mPulse = 1'b0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        pressed = '0;
        mHeld   = 1'b0;
        mCode   = 4'h0;
        mPulse  = 1'b0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        check("init_col",   kp.col,       4'b0111);
        check("init_code",  kp.key_code,  4'h0);
        check("init_valid", kp.key_valid, 1'b0);
        check("init_held",  kp.key_held,  1'b0);
        rst = 1'b0;

        // reset mid-sweep, rotation resumes
        sweep(16'h0000);
        midSweepReset();
        sweeps(16'h0000, 2);

        // hold "5" then release
        sweeps(16'h0020, 4);
        sweeps(16'h0000, 4);

        // "5" for two sweeps only
        sweeps(16'h0020, 2);
        sweeps(16'h0000, 3);

        // "1" + "D" ghosting, then "1" alone
        sweeps(16'h8001, 6);
        sweeps(16'h0001, 4);
        sweeps(16'h0000, 3);

        // direct switch "A" -> "0"
        sweeps(16'h0008, 4);
        sweeps(16'h1000, 4);
        sweeps(16'h0000, 3);

        // reset in the middle of debouncing a press
        sweeps(16'h0020, 2);
        midSweepReset();
        sweeps(16'h0000, 1);

        // every key in turn
        for (int k = 0; k < 16; k++) begin
            sweeps(16'(1) << k, N);
            sweeps(16'h0000, N);
        end

        // random presses, releases, ghosts and glitches
        for (int seg = 0; seg < 50; seg++) begin
            int          kind;
            int          a;
            int          b;
            logic [15:0] p;
            kind = int'($urandom_range(0, 7));
            a    = int'($urandom_range(0, 15));
            b    = (a + int'($urandom_range(1, 15))) % 16;
            if (kind <= 4)      p = 16'(1) << a;
            else if (kind == 5) p = 16'h0000;
            else                p = (16'(1) << a) | (16'(1) << b);
            sweeps(p, int'($urandom_range(1, 5)));
        end
        sweeps(16'h0000, N + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
